// File: rtl/bram_pl_pkg.sv
// Shared types, widths and helpers for the BRAM preload (PL_*) bus loader.
// Used by bram_pl_loader and bram_pl_rsp_slot.
package bram_pl_pkg;

   localparam int unsigned PL_ADDR_W = 32;
   localparam int unsigned PL_DATA_W = 36;
   localparam int unsigned RAM_ID_W  = 17;
   localparam int unsigned WADDR_W   = 15;

   typedef enum logic [1:0] {
      OpNop   = 2'b00,
      OpWrite = 2'b01,
      OpRead  = 2'b10,
      OpInit  = 2'b11
   } bram_pl_op_e;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StInit  = 3'd1,
      StWrite = 3'd2,
      StRead  = 3'd3,
      StWait  = 3'd4,
      StResp  = 3'd5
   } bram_pl_state_e;

   function automatic logic [PL_ADDR_W-1:0] pl_pack_addr(input logic [RAM_ID_W-1:0] ram_id,
                                                         input logic [WADDR_W-1:0]  addr);
      return {ram_id, addr};
   endfunction

endpackage

// File: rtl/bram_pl_rsp_slot.sv
// Single-entry readback holding register with a valid/ready handshake.
// Data stays stable while valid until the consumer accepts it.
module bram_pl_rsp_slot
   import bram_pl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [PL_DATA_W-1:0] data_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [PL_DATA_W-1:0] data_o
);

   logic                 valid_q, valid_d;
   logic [PL_DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/bram_pl_loader.sv
// Upstream driver for the QL_BRAM preload chain: turns write/read/init commands into PL_* cycles.
// Readback (READ/WAIT/RESP and the response slot) is only built with BRAM_PL_READBACK_EN.
module bram_pl_loader
   import bram_pl_pkg::*;
#(
   parameter int unsigned RD_LATENCY  = 2,
   parameter int unsigned INIT_CYCLES = 4
) (
   input  logic                 PL_CLK_i,
   input  logic                 global_resetn,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [1:0]           cmd_op_i,
   input  logic [RAM_ID_W-1:0]  cmd_ram_id_i,
   input  logic [WADDR_W-1:0]   cmd_addr_i,
   input  logic [1:0]           cmd_wen_i,
   input  logic [PL_DATA_W-1:0] cmd_data_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [PL_DATA_W-1:0] rsp_data_o,
   input  logic [PL_DATA_W-1:0] PL_DATA_i,
   output logic                 PL_INIT_o,
   output logic                 PL_ENA_o,
   output logic                 PL_REN_o,
   output logic [1:0]           PL_WEN_o,
   output logic [PL_ADDR_W-1:0] PL_ADDR_o,
   output logic [PL_DATA_W-1:0] PL_DATA_o,
   output logic                 PL_CLK_o,
   output logic                 busy_o
);

   localparam logic [7:0] InitLast = 8'(INIT_CYCLES - 1);

   bram_pl_state_e       state_q, state_d;
   bram_pl_op_e          op;
   logic                 accept;
   logic                 cmd_ready_q;
   logic [7:0]           init_cnt_q, init_cnt_d;
   logic                 ena_q, init_q;
   logic [1:0]           wen_q;
   logic [PL_ADDR_W-1:0] addr_q;
   logic [PL_DATA_W-1:0] data_q;

   assign accept = cmd_valid_i & cmd_ready_q;
   assign op     = bram_pl_op_e'(cmd_op_i);

`ifdef BRAM_PL_READBACK_EN
   localparam logic [3:0] WaitLast = 4'(RD_LATENCY - 1);

   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       capture;
   logic       ren_q;
   logic       rsp_valid;
`endif

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
`ifdef BRAM_PL_READBACK_EN
      wait_cnt_d = wait_cnt_q;
      capture    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (op)
                  OpWrite: state_d = StWrite;
                  OpInit: begin
                     state_d    = StInit;
                     init_cnt_d = InitLast;
                  end
`ifdef BRAM_PL_READBACK_EN
                  OpRead:  state_d = StRead;
`endif
                  default: state_d = StIdle;
               endcase
            end
         end
         StWrite: state_d = StIdle;
         StInit: begin
            if (init_cnt_q == 8'd0) state_d = StIdle;
            else                    init_cnt_d = init_cnt_q - 8'd1;
         end
`ifdef BRAM_PL_READBACK_EN
         StRead: begin
            state_d    = StWait;
            wait_cnt_d = WaitLast;
         end
         StWait: begin
            // PL_DATA_i is valid on the last wait cycle; slot loads at its closing edge
            if (wait_cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_valid && rsp_ready_i) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PL_CLK_i or negedge global_resetn) begin
      if (!global_resetn) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         init_cnt_q  <= '0;
         ena_q       <= 1'b0;
         init_q      <= 1'b0;
         wen_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= (state_d == StIdle);
         init_cnt_q  <= init_cnt_d;
         ena_q       <= (state_d == StWrite) || (state_d == StRead);
         init_q      <= (state_d == StInit);
         wen_q       <= (state_d == StWrite) ? cmd_wen_i : 2'b00;
         if (accept && ((state_d == StWrite) || (state_d == StRead))) begin
            addr_q <= pl_pack_addr(cmd_ram_id_i, cmd_addr_i);
         end
         if (accept && (state_d == StWrite)) begin
            data_q <= cmd_data_i;
         end
      end
   end

`ifdef BRAM_PL_READBACK_EN
   always_ff @(posedge PL_CLK_i or negedge global_resetn) begin
      if (!global_resetn) begin
         wait_cnt_q <= '0;
         ren_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         ren_q      <= (state_d == StRead);
      end
   end

   bram_pl_rsp_slot u_rsp_slot (
      .clk_i   (PL_CLK_i),
      .rst_ni  (global_resetn),
      .load_i  (capture),
      .data_i  (PL_DATA_i),
      .ready_i (rsp_ready_i),
      .valid_o (rsp_valid),
      .data_o  (rsp_data_o)
   );

   assign rsp_valid_o = rsp_valid;
   assign PL_REN_o    = ren_q;
`else
   logic unused_readback;
   assign unused_readback = ^{PL_DATA_i, rsp_ready_i};

   assign rsp_valid_o = 1'b0;
   assign rsp_data_o  = '0;
   assign PL_REN_o    = 1'b0;
`endif

   assign cmd_ready_o = cmd_ready_q;
   assign PL_ENA_o    = ena_q;
   assign PL_INIT_o   = init_q;
   assign PL_WEN_o    = wen_q;
   assign PL_ADDR_o   = addr_q;
   assign PL_DATA_o   = data_q;
   assign PL_CLK_o    = PL_CLK_i;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_bram_pl_loader.sv
// Directed bench for bram_pl_loader; readback steps follow BRAM_PL_READBACK_EN.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bram_pl_loader;

   localparam int unsigned RdLat   = 2;
   localparam int unsigned InitCyc = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [16:0] cmd_ram_id;
   logic [14:0] cmd_addr;
   logic [1:0]  cmd_wen;
   logic [35:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [35:0] rsp_data;
   logic [35:0] pl_data_in;
   logic        pl_init, pl_ena, pl_ren, pl_clk;
   logic [1:0]  pl_wen;
   logic [31:0] pl_addr;
   logic [35:0] pl_data_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bram_pl_loader #(
      .RD_LATENCY  (RdLat),
      .INIT_CYCLES (InitCyc)
   ) dut (
      .PL_CLK_i      (clk),
      .global_resetn (rst_n),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_op_i      (cmd_op),
      .cmd_ram_id_i  (cmd_ram_id),
      .cmd_addr_i    (cmd_addr),
      .cmd_wen_i     (cmd_wen),
      .cmd_data_i    (cmd_data),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_data_o    (rsp_data),
      .PL_DATA_i     (pl_data_in),
      .PL_INIT_o     (pl_init),
      .PL_ENA_o      (pl_ena),
      .PL_REN_o      (pl_ren),
      .PL_WEN_o      (pl_wen),
      .PL_ADDR_o     (pl_addr),
      .PL_DATA_o     (pl_data_out),
      .PL_CLK_o      (pl_clk),
      .busy_o        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [1:0] op, input logic [16:0] id, input logic [14:0] a,
                      input logic [1:0] w, input logic [35:0] d);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_ram_id = id;
      cmd_addr   = a;
      cmd_wen    = w;
      cmd_data   = d;
   endtask

   initial begin
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_ram_id = '0;
      cmd_addr   = '0;
      cmd_wen    = '0;
      cmd_data   = '0;
      rsp_ready  = 1'b0;
      pl_data_in = '0;

      // reset
      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_ena", pl_ena, 0);
      chk("rst_init", pl_init, 0);
      chk("rst_addr", pl_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("clk_fwd", pl_clk, clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1);

      // write with both halves enabled
      cmd(2'b01, 17'h00005, 15'h0012, 2'b11, 36'h9_ABCD_1234);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wr_ena", pl_ena, 1);
      chk("wr_wen", pl_wen, 2'b11);
      chk("wr_addr", pl_addr, 32'h0002_8012);
      chk("wr_data", pl_data_out, 36'h9_ABCD_1234);
      chk("wr_ready_low", cmd_ready, 0);
      chk("wr_busy", busy, 1);
      chk("wr_ren", pl_ren, 0);
      @(negedge clk);
      chk("wr_ena_drop", pl_ena, 0);
      chk("wr_wen_drop", pl_wen, 0);
      chk("wr_ready_back", cmd_ready, 1);
      chk("wr_addr_hold", pl_addr, 32'h0002_8012);
      chk("wr_data_hold", pl_data_out, 36'h9_ABCD_1234);

      // write with no half enabled still issues an ENA cycle
      cmd(2'b01, 17'h1ABCD, 15'h7FFF, 2'b00, 36'h0_0000_0001);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wr0_ena", pl_ena, 1);
      chk("wr0_wen", pl_wen, 2'b00);
      chk("wr0_addr", pl_addr, 32'hD5E6_FFFF);
      chk("wr0_data", pl_data_out, 36'h0_0000_0001);
      @(negedge clk);

      // nop is consumed without leaving IDLE
      cmd(2'b00, 17'h00001, 15'h0001, 2'b11, 36'h1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("nop_ready", cmd_ready, 1);
      chk("nop_busy", busy, 0);
      chk("nop_ena", pl_ena, 0);
      chk("nop_addr_hold", pl_addr, 32'hD5E6_FFFF);

      // init pulse, with a write waiting behind it
      cmd(2'b11, 17'h0, 15'h0, 2'b00, 36'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < InitCyc; i++) begin
         chk("init_high", pl_init, 1);
         chk("init_ena", pl_ena, 0);
         chk("init_ready", cmd_ready, 0);
         if (i == InitCyc - 1) cmd(2'b01, 17'h1FFFF, 15'h7FFF, 2'b01, 36'hF_0000_000F);
         @(negedge clk);
      end
      chk("init_low", pl_init, 0);
      chk("init_ready_back", cmd_ready, 1);
      chk("b2b_ena_pre", pl_ena, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b_ena", pl_ena, 1);
      chk("b2b_wen", pl_wen, 2'b01);
      chk("b2b_addr", pl_addr, 32'hFFFF_FFFF);
      chk("b2b_data", pl_data_out, 36'hF_0000_000F);
      @(negedge clk);
      chk("b2b_ena_drop", pl_ena, 0);

      // reset during init drops the pulse and does not resume it
      cmd(2'b11, 17'h0, 15'h0, 2'b00, 36'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rinit_high", pl_init, 1);
      rst_n = 1'b0;
      #1;
      chk("rinit_async_init", pl_init, 0);
      chk("rinit_async_ready", cmd_ready, 0);
      chk("rinit_async_busy", busy, 0);
      chk("rinit_async_addr", pl_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rinit_ready", cmd_ready, 1);
      chk("rinit_no_resume", pl_init, 0);
      @(negedge clk);
      chk("rinit_no_resume2", pl_init, 0);

`ifdef BRAM_PL_READBACK_EN
      // read, response accepted immediately
      rsp_ready  = 1'b1;
      pl_data_in = 36'h0_DEAD_BEEF;
      cmd(2'b10, 17'h00001, 15'h0003, 2'b00, 36'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rd_ren", pl_ren, 1);
      chk("rd_ena", pl_ena, 1);
      chk("rd_addr", pl_addr, 32'h0000_8003);
      chk("rd_ready_low", cmd_ready, 0);
      @(negedge clk);
      chk("rd_ren_pulse", pl_ren, 0);
      chk("rd_ena_off", pl_ena, 0);
      chk("rd_valid_early1", rsp_valid, 0);
      @(negedge clk);
      pl_data_in = 36'h1_2345_6789;
      chk("rd_valid_early2", rsp_valid, 0);
      @(negedge clk);
      pl_data_in = 36'hF_FFFF_FFFF;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, 36'h1_2345_6789);
      chk("rd_resp_ready", cmd_ready, 0);
      chk("rd_resp_busy", busy, 1);
      @(negedge clk);
      chk("rd_valid_drop", rsp_valid, 0);
      chk("rd_idle_ready", cmd_ready, 1);
      chk("rd_idle_busy", busy, 0);

      // read with back-pressure on the response
      rsp_ready  = 1'b0;
      pl_data_in = 36'hA_BCDE_0123;
      cmd(2'b10, 17'h00002, 15'h0040, 2'b00, 36'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_addr", pl_addr, 32'h0001_0040);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, 36'hA_BCDE_0123);
         chk("bp_ready", cmd_ready, 0);
         pl_data_in = 36'h0;
         if (i == 4) rsp_ready = 1'b1;
         @(negedge clk);
      end
      chk("bp_valid_drop", rsp_valid, 0);
      chk("bp_idle", cmd_ready, 1);

      // reset while waiting for read data
      rsp_ready = 1'b0;
      cmd(2'b10, 17'h00003, 15'h0001, 2'b00, 36'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rw_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_ready", cmd_ready, 0);
      chk("rw_busy_clr", busy, 0);
      chk("rw_rsp_valid", rsp_valid, 0);
      chk("rw_rsp_data", rsp_data, 0);
      chk("rw_ren", pl_ren, 0);
      chk("rw_addr", pl_addr, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rw_no_rsp", rsp_valid, 0);
      end
      chk("rw_ready_back", cmd_ready, 1);
      cmd(2'b01, 17'h00000, 15'h0001, 2'b10, 36'h0_0000_0005);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rw_wr_ena", pl_ena, 1);
      chk("rw_wr_wen", pl_wen, 2'b10);
      chk("rw_wr_addr", pl_addr, 32'h0000_0001);
      chk("rw_wr_data", pl_data_out, 36'h0_0000_0005);
      @(negedge clk);
`else
      // without readback a read is a nop
      rsp_ready  = 1'b1;
      pl_data_in = 36'h1_2345_6789;
      cmd(2'b10, 17'h00004, 15'h0004, 2'b11, 36'h3);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("nrd_ready", cmd_ready, 1);
      chk("nrd_busy", busy, 0);
      chk("nrd_ena", pl_ena, 0);
      chk("nrd_addr_hold", pl_addr, 0);
      for (int i = 0; i < 4; i++) begin
         chk("nrd_ren", pl_ren, 0);
         chk("nrd_rsp_valid", rsp_valid, 0);
         chk("nrd_rsp_data", rsp_data, 0);
         @(negedge clk);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_pl_loader.md
# bram_pl_loader

Upstream driver for the BRAM preload (PL_*) bus that feeds the chain of QL_BRAM tiles. It accepts write, read and init commands over a valid/ready stream from the configuration controller, and converts each one into correctly timed PL_INIT/PL_ENA/PL_REN/PL_WEN/PL_ADDR/PL_DATA cycles. Readback data returning from the end of the chain is captured and presented on a valid/ready response port. One instance drives one BRAM chain.

## Interface
- RD_LATENCY, 2: cycles from the PL_REN pulse to valid PL_DATA_i; legal range 1..15.
- INIT_CYCLES, 4: length of the PL_INIT_o pulse in cycles; legal range 1..255.
- PL_CLK_i  in  1  sole clock; also forwarded combinationally as PL_CLK_o.
- global_resetn  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_op_i  in  2  01 write, 10 read, 11 init, 00 nop.
- cmd_ram_id_i  in  17  target RAM_ID.
- cmd_addr_i  in  15  word address.
- cmd_wen_i  in  2  half-word write enables.
- cmd_data_i  in  36  write data.
- rsp_valid_o  out  1  readback valid.
- rsp_ready_i  in  1  readback ready.
- rsp_data_o  out  36  readback word.
- PL_DATA_i  in  36  readback data from the chain end.
- PL_INIT_o, PL_ENA_o, PL_REN_o  out  1 each  preload controls.
- PL_WEN_o  out  2  half-word write enables.
- PL_ADDR_o  out  32  {ram_id[16:0], addr[14:0]}.
- PL_DATA_o  out  36  write data.
- PL_CLK_o  out  1  forwarded clock.
- busy_o  out  1  high whenever the FSM state is not IDLE.

## Operation
- FSM states: IDLE, INIT, WRITE, READ, WAIT, RESP.
- Handshake:
  - cmd_ready_o = (state == IDLE), registered.
  - A command is accepted on cmd_valid_i & cmd_ready_o, and all cmd fields are latched on acceptance.
  - rsp_valid_o and rsp_data_o stay stable until rsp_ready_i is sampled high.
- nop: consumed; the FSM stays in IDLE.
- write: IDLE→WRITE for 1 cycle.
  - Drives PL_ENA_o=1, PL_WEN_o=cmd_wen, PL_ADDR_o and PL_DATA_o from the latched command.
  - Then returns to IDLE.
  - cmd_wen=00 still issues the PL_ENA cycle, with PL_WEN_o=00.
- read: IDLE→READ for 1 cycle, driving PL_ENA_o=1, PL_REN_o=1 and PL_ADDR_o.
  - READ→WAIT. A 4-bit counter counts RD_LATENCY cycles.
  - On the last WAIT cycle, PL_DATA_i is captured into rsp_data_o → RESP.
  - RESP raises rsp_valid_o. On rsp_ready_i the FSM goes to IDLE.
- init: IDLE→INIT. PL_INIT_o=1 for exactly INIT_CYCLES cycles, with PL_ENA_o=0, then IDLE.
- In every state other than those listed above, PL_ENA_o, PL_REN_o, PL_WEN_o and PL_INIT_o are 0. PL_ADDR_o and PL_DATA_o hold their last driven value.
- Reset mid-operation:
  - All state and outputs clear immediately.
  - A pending response is discarded.
  - A partially elapsed init pulse is not resumed.

## Timing
- All PL_* outputs except PL_CLK_o are registered.
- Reset values:
  - cmd_ready_o=0 while reset is asserted, 1 on the first clock after deassertion.
  - All other outputs, including rsp_data_o, are 0.
- Write: accepted at edge N; PL_ENA_o is high for cycle N+1; cmd_ready_o is high again at N+2. Maximum throughput is 1 write per 2 cycles.
- Read: PL_REN_o is high in cycle N+1. Capture happens at edge N+1+RD_LATENCY. rsp_valid_o is high from N+2+RD_LATENCY.
- Init: PL_INIT_o is high for cycles N+1 .. N+INIT_CYCLES. cmd_ready_o returns at N+INIT_CYCLES+1.
- RESP with rsp_ready_i already high: one RESP cycle, then IDLE.

## Configuration
- BRAM_PL_READBACK_EN defined: read ops behave as specified above.
- BRAM_PL_READBACK_EN undefined:
  - The READ, WAIT and RESP states and the capture register are not compiled.
  - op 10 is consumed as a nop.
  - PL_REN_o, rsp_valid_o and rsp_data_o are tied to 0.
  - PL_DATA_i is unused.

## Structure
- Shared package bram_pl_pkg holds:
  - the op encoding enum;
  - the state enum;
  - widths PL_ADDR_W=32, PL_DATA_W=36, RAM_ID_W=17, WADDR_W=15;
  - an address-pack function.
- Sub-module bram_pl_rsp_slot: single-entry response holding register with the valid/ready handshake. Instantiated only under BRAM_PL_READBACK_EN.

## Test plan
- Reset, then write op with ram_id=0x00005, addr=0x0012, wen=11, data=0x9_ABCD_1234 → one cycle with PL_ENA_o=1, PL_WEN_o=11, PL_ADDR_o=0x0002_8012, PL_DATA_o=0x9ABCD1234; cmd_ready_o back 2 cycles after acceptance.
- Read with RD_LATENCY=2 and PL_DATA_i=0x1_2345_6789 driven in the capture cycle → PL_REN_o is a 1-cycle pulse; rsp_valid_o rises 4 cycles after acceptance with rsp_data_o=0x123456789.
- Read with rsp_ready_i held low for 5 cycles → rsp_valid_o and rsp_data_o stable, cmd_ready_o=0 throughout; IDLE the cycle after rsp_ready_i=1.
- Init with INIT_CYCLES=4 → PL_INIT_o high for exactly 4 cycles, PL_ENA_o=0; back-to-back write is accepted on the next IDLE cycle.
- global_resetn asserted during WAIT → all outputs 0 asynchronously; after release no rsp_valid_o; the next command behaves normally.
- Build without BRAM_PL_READBACK_EN: read command → consumed in 1 cycle, PL_REN_o and rsp_valid_o never assert.
